// File: rtl/frag_buffer_wr_arbiter.sv
// Write-port arbiter for the fragmentation buffer: grants whole TLPs round-robin
// and admits a beat only when the buffer has room for it after any in-flight write.
module frag_buffer_wr_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int LOC_WIDTH       = 128,
  parameter int MAX_LOC         = 8,
  parameter int WR_DATA_WIDTH   = LOC_WIDTH * MAX_LOC,
  parameter int NO_LOC_WR_WIDTH = 4,
  parameter int COUNT_WIDTH     = 9,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*WR_DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*NO_LOC_WR_WIDTH-1:0] req_no_loc,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               wr_en,
  output logic [WR_DATA_WIDTH-1:0]           data_in,
  output logic [NO_LOC_WR_WIDTH-1:0]         no_loc_wr,
  input  logic [COUNT_WIDTH-1:0]             empty_loc,
  output logic [ID_WIDTH-1:0]                grant_id,
  output logic                               busy
);

  // state  | meaning
  // IDLE   | no owner; next owner is chosen round-robin starting at rr_ptr
  // LOCKED | grant_id owns the write port until its last beat is accepted

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [NO_LOC_WR_WIDTH-1:0] MAX_LOC_W = NO_LOC_WR_WIDTH'(MAX_LOC);

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                       own_valid;
  logic                       own_last;
  logic [NO_LOC_WR_WIDTH-1:0] own_no_loc;
  logic [WR_DATA_WIDTH-1:0]   own_data;

  always_comb begin
    own_valid  = 1'b0;
    own_last   = 1'b0;
    own_no_loc = '0;
    own_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        own_valid  = req_valid[i];
        own_last   = req_last[i];
        own_no_loc = req_no_loc[i*NO_LOC_WR_WIDTH +: NO_LOC_WR_WIDTH];
        own_data   = req_data[i*WR_DATA_WIDTH +: WR_DATA_WIDTH];
      end
    end
  end

  // empty_loc lags our own write by one cycle, so the registered write is deducted here.
  logic [COUNT_WIDTH:0] in_flight;
  logic [COUNT_WIDTH:0] avail_raw;
  logic [COUNT_WIDTH:0] avail;
  logic                 room;
  logic                 accept;

  assign in_flight = wr_en ? (COUNT_WIDTH+1)'(no_loc_wr) : '0;
  assign avail_raw = {1'b0, empty_loc} - in_flight;
  assign avail     = avail_raw[COUNT_WIDTH] ? '0 : avail_raw;
  assign room      = (avail >= (COUNT_WIDTH+1)'(own_no_loc));
  assign accept    = (state == LOCKED) && own_valid && room;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == LOCKED) && (grant_id == ID_WIDTH'(i))) begin
        req_ready[i] = own_valid && room;
      end
    end
  end

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall.
  logic                any_hi;
  logic [ID_WIDTH-1:0] win_hi;
  logic [ID_WIDTH-1:0] win_lo;
  logic [ID_WIDTH-1:0] winner;

  always_comb begin
    any_hi = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        win_lo = ID_WIDTH'(j);
      end
      if (req_valid[j] && (ID_WIDTH'(j) >= rr_ptr)) begin
        any_hi = 1'b1;
        win_hi = ID_WIDTH'(j);
      end
    end
    winner = any_hi ? win_hi : win_lo;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      data_in   <= '0;
      no_loc_wr <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            // A zero-location beat only carries the end-of-TLP marker.
            if (own_no_loc != '0) begin
              wr_en     <= 1'b1;
              data_in   <= own_data;
              no_loc_wr <= own_no_loc;
            end
            if (own_last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A beat wider than the data bus is a requester bug with no defined recovery.
  a_no_loc_legal : assert property (@(posedge clk) disable iff (arst)
    ((state == LOCKED) && own_valid) |-> (own_no_loc <= MAX_LOC_W));

endmodule
